// File: rtl/matrix_vec_mac_stream.sv
// Streams one matrix row of A polynomials against vector s and accumulates
// sum_c A[c][k]*s[c][k] mod Q per coefficient k, then dumps the N sums in order.
module matrix_vec_mac_stream #(
  parameter  int W        = 24,
  parameter  int Q        = 8380417,
  parameter  int LOGN     = 8,
  parameter  int MAX_COLS = 7,
  localparam int CW       = $clog2(MAX_COLS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [CW-1:0]   i_ncols,
  input  logic            i_abort,
  input  logic [W-1:0]    i_a_data,
  input  logic            i_a_valid,
  output logic            o_a_ready,
  output logic [LOGN-1:0] o_s_addr,
  output logic [CW-1:0]   o_s_col,
  input  logic [W-1:0]    i_s_data,
  output logic [W-1:0]    o_res_data,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic            o_res_last,
  output logic            o_busy
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN-1:0] LAST_K  = LOGN'(N - 1);
  localparam logic [2*W-1:0]  Q_WIDE  = (2*W)'(Q);
  localparam logic [W:0]      Q_W1    = (W+1)'(Q);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CALC  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] DUMP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      r_state;
  logic [CW-1:0]   r_ncols;
  logic [LOGN-1:0] r_coef;
  logic [CW-1:0]   r_col;
  logic [1:0]      r_drain;
  logic [LOGN-1:0] r_dump_idx;
  logic            r_res_valid;
  logic            r_res_last;

  logic [3:1]            r_v;
  logic [3:1][LOGN-1:0]  r_k;
  logic [3:1]            r_first;
  logic [W-1:0]          r_a1;
  logic [2*W-1:0]        r_prod;
  logic [W-1:0]          r_p3;

  logic [W-1:0] r_acc [N];
  logic [W-1:0] r_rd_raw;
  logic         r_fwd_sel;
  logic [W-1:0] r_fwd_data;

  logic [CW-1:0]   w_ncols_clamped;
  logic            w_abort;
  logic            w_beat;
  logic            w_last_beat;
  logic [W-1:0]    w_acc_old;
  logic [W:0]      w_sum_raw;
  logic [W-1:0]    w_sum_red;
  logic [W-1:0]    w_wdata;
  logic            w_res_take;
  logic            w_res_fin;
  logic [LOGN-1:0] w_raddr;
  logic            w_re;

  always_comb begin
    w_ncols_clamped = i_ncols;
    if (i_ncols == '0)
      w_ncols_clamped = CW'(1);
    else if (i_ncols > CW'(MAX_COLS))
      w_ncols_clamped = CW'(MAX_COLS);
  end

  assign w_abort     = i_abort && (r_state != IDLE);
  assign w_beat      = (r_state == CALC) && i_a_valid;
  assign w_last_beat = w_beat && (r_coef == LAST_K) && (r_col == r_ncols - CW'(1));

  // The write landing on the same edge as a read is invisible to that read, so it is forwarded.
  assign w_acc_old = r_fwd_sel ? r_fwd_data : r_rd_raw;
  assign w_sum_raw = {1'b0, w_acc_old} + {1'b0, r_p3};
  assign w_sum_red = (w_sum_raw >= Q_W1) ? W'(w_sum_raw - Q_W1) : w_sum_raw[W-1:0];
  assign w_wdata   = r_first[3] ? r_p3 : w_sum_red;

  assign w_res_take = (r_state == DUMP) && (!r_res_valid || i_res_ready) && !r_res_last;
  assign w_res_fin  = (r_state == DUMP) && r_res_valid && r_res_last && i_res_ready;
  assign w_raddr    = (r_state == DUMP) ? r_dump_idx : r_k[2];
  assign w_re       = (r_state != DUMP) || w_res_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ncols     <= '0;
      r_coef      <= '0;
      r_col       <= '0;
      r_drain     <= '0;
      r_dump_idx  <= '0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
    end else if (w_abort) begin
      r_state     <= IDLE;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_state <= CALC;
            r_ncols <= w_ncols_clamped;
            r_coef  <= '0;
            r_col   <= '0;
          end
        end
        CALC: begin
          if (w_last_beat) begin
            r_state <= DRAIN;
            r_drain <= '0;
            r_coef  <= '0;
          end else if (w_beat) begin
            if (r_coef == LAST_K) begin
              r_coef <= '0;
              r_col  <= r_col + CW'(1);
            end else begin
              r_coef <= r_coef + LOGN'(1);
            end
          end
        end
        DRAIN: begin
          if (r_drain == 2'd3) begin
            r_state     <= DUMP;
            r_dump_idx  <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        DUMP: begin
          if (w_res_fin) begin
            r_state     <= DONE;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
          end else if (w_res_take) begin
            r_res_valid <= 1'b1;
            r_res_last  <= (r_dump_idx == LAST_K);
            r_dump_idx  <= r_dump_idx + LOGN'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage tags: 1 = a captured, 2 = product, 3 = reduced product + old accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v        <= '0;
      r_k        <= '0;
      r_first    <= '0;
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_v        <= w_abort ? 3'b000 : {r_v[2:1], w_beat};
      r_k        <= {r_k[2:1], r_coef};
      r_first    <= {r_first[2:1], (r_col == '0)};
      r_fwd_sel  <= r_v[3] && r_v[2] && (r_k[3] == r_k[2]) && !w_abort;
      r_fwd_data <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat)
      r_a1 <= i_a_data;
    r_prod <= {{W{1'b0}}, r_a1} * {{W{1'b0}}, i_s_data};
    r_p3   <= W'(r_prod % Q_WIDE);
  end

  always_ff @(posedge clk) begin
    if (r_v[3])
      r_acc[r_k[3]] <= w_wdata;
    if (w_re)
      r_rd_raw <= r_acc[w_raddr];
  end

  assign o_a_ready   = (r_state == CALC);
  assign o_s_addr    = r_coef;
  assign o_s_col     = r_col;
  assign o_res_valid = r_res_valid;
  assign o_res_last  = r_res_last;
  assign o_res_data  = r_res_valid ? r_rd_raw : '0;
  assign o_busy      = (r_state != IDLE);

endmodule
